// File: rtl/vx_l1_mem_sched.sv
// Shares the socket L1 memory port between the icache and dcache miss paths:
// icache-priority arbitration with a dcache starvation guard, per-source read tracking, response routing.
module vx_l1_mem_sched #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_WIDTH    = 8,
    parameter int MAX_PENDING  = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      icache_req_valid,
    input  logic [ADDR_WIDTH-1:0]     icache_req_addr,
    input  logic [TAG_WIDTH-1:0]      icache_req_tag,
    output logic                      icache_req_ready,

    input  logic                      dcache_req_valid,
    input  logic                      dcache_req_rw,
    input  logic [ADDR_WIDTH-1:0]     dcache_req_addr,
    input  logic [DATA_WIDTH-1:0]     dcache_req_data,
    input  logic [DATA_WIDTH/8-1:0]   dcache_req_byteen,
    input  logic [TAG_WIDTH-1:0]      dcache_req_tag,
    output logic                      dcache_req_ready,

    output logic                      mem_req_valid,
    output logic                      mem_req_rw,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_data,
    output logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
    output logic [TAG_WIDTH:0]        mem_req_tag,
    input  logic                      mem_req_ready,

    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    input  logic [TAG_WIDTH:0]        mem_rsp_tag,
    output logic                      mem_rsp_ready,

    output logic                      icache_rsp_valid,
    output logic [DATA_WIDTH-1:0]     icache_rsp_data,
    output logic [TAG_WIDTH-1:0]      icache_rsp_tag,
    input  logic                      icache_rsp_ready,

    output logic                      dcache_rsp_valid,
    output logic [DATA_WIDTH-1:0]     dcache_rsp_data,
    output logic [TAG_WIDTH-1:0]      dcache_rsp_tag,
    input  logic                      dcache_rsp_ready,

    output logic                      rsp_err,
    output logic                      busy
);

    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int PEND_W   = $clog2(MAX_PENDING + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PEND_W-1:0]   PEND_MAX   = PEND_W'(MAX_PENDING);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [PEND_W-1:0]   icache_pend;
    logic [PEND_W-1:0]   dcache_pend;
    logic [STARVE_W-1:0] starve;

    logic can_load;
    logic i_ok;
    logic d_ok;
    logic grant_i;
    logic grant_d;
    logic acc_i;
    logic acc_d;
    logic inc_i;
    logic inc_d;
    logic dec_i;
    logic dec_d;
    logic rsp_src;
    logic rsp_fire;

    // ---------------- arbitration ----------------
    assign can_load = !mem_req_valid || mem_req_ready;
    assign i_ok     = icache_req_valid && (icache_pend < PEND_MAX);
    assign d_ok     = dcache_req_valid && (dcache_req_rw || (dcache_pend < PEND_MAX));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_ok && (starve == STARVE_MAX)) begin
            grant_d = 1'b1;
        end else if (i_ok) begin
            grant_i = 1'b1;
        end else if (d_ok) begin
            grant_d = 1'b1;
        end
    end

    // Readies are masked while reset is held so nothing is handshaken during reset.
    assign icache_req_ready = reset && can_load && grant_i;
    assign dcache_req_ready = reset && can_load && grant_d;

    assign acc_i = can_load && grant_i;
    assign acc_d = can_load && grant_d;

    // Starvation guard: counts cycles a serviceable dcache request loses to the icache.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (can_load) begin
            if (grant_d || !dcache_req_valid) begin
                starve <= '0;
            end else if (d_ok && (starve != STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_valid  <= 1'b0;
            mem_req_rw     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_data   <= '0;
            mem_req_byteen <= '0;
            mem_req_tag    <= '0;
        end else if (acc_i) begin
            mem_req_valid  <= 1'b1;
            mem_req_rw     <= 1'b0;
            mem_req_addr   <= icache_req_addr;
            mem_req_data   <= '0;
            mem_req_byteen <= {BE_W{1'b1}};
            mem_req_tag    <= {1'b0, icache_req_tag};
        end else if (acc_d) begin
            mem_req_valid  <= 1'b1;
            mem_req_rw     <= dcache_req_rw;
            mem_req_addr   <= dcache_req_addr;
            mem_req_data   <= dcache_req_data;
            mem_req_byteen <= dcache_req_rw ? dcache_req_byteen : {BE_W{1'b1}};
            mem_req_tag    <= {1'b1, dcache_req_tag};
        end else if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
        end
    end

    // ---------------- response routing ----------------
    assign rsp_src = mem_rsp_tag[TAG_WIDTH];

    assign icache_rsp_valid = reset && mem_rsp_valid && !rsp_src;
    assign dcache_rsp_valid = reset && mem_rsp_valid &&  rsp_src;
    assign icache_rsp_data  = mem_rsp_data;
    assign dcache_rsp_data  = mem_rsp_data;
    assign icache_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign dcache_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign mem_rsp_ready    = reset && (rsp_src ? dcache_rsp_ready : icache_rsp_ready);

    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    // ---------------- outstanding-read tracking ----------------
    assign inc_i = acc_i;
    assign inc_d = acc_d && !dcache_req_rw;
    assign dec_i = rsp_fire && !rsp_src;
    assign dec_d = rsp_fire &&  rsp_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icache_pend <= '0;
            dcache_pend <= '0;
        end else begin
            if (inc_i && !dec_i) begin
                icache_pend <= icache_pend + 1'b1;
            end else if (!inc_i && dec_i && (icache_pend != '0)) begin
                icache_pend <= icache_pend - 1'b1;
            end
            if (inc_d && !dec_d) begin
                dcache_pend <= dcache_pend + 1'b1;
            end else if (!inc_d && dec_d && (dcache_pend != '0)) begin
                dcache_pend <= dcache_pend - 1'b1;
            end
        end
    end

    // A response for a source with nothing outstanding is a protocol error; latched until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err <= 1'b0;
        end else if ((dec_i && !inc_i && (icache_pend == '0)) ||
                     (dec_d && !inc_d && (dcache_pend == '0))) begin
            rsp_err <= 1'b1;
        end
    end

    assign busy = mem_req_valid || (icache_pend != '0) || (dcache_pend != '0);

endmodule

// File: tb/tb_vx_l1_mem_sched.sv
// Directed self-checking bench for vx_l1_mem_sched: reset, priority/starvation,
// back-pressure, pending limit, response routing, writes and error flag.
module tb_vx_l1_mem_sched;

    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_req_valid;
    logic [AW-1:0] icache_req_addr;
    logic [TW-1:0] icache_req_tag;
    logic          icache_req_ready;
    logic          dcache_req_valid;
    logic          dcache_req_rw;
    logic [AW-1:0] dcache_req_addr;
    logic [DW-1:0] dcache_req_data;
    logic [BW-1:0] dcache_req_byteen;
    logic [TW-1:0] dcache_req_tag;
    logic          dcache_req_ready;
    logic          mem_req_valid;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [BW-1:0] mem_req_byteen;
    logic [TW:0]   mem_req_tag;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW:0]   mem_rsp_tag;
    logic          mem_rsp_ready;
    logic          icache_rsp_valid;
    logic [DW-1:0] icache_rsp_data;
    logic [TW-1:0] icache_rsp_tag;
    logic          icache_rsp_ready;
    logic          dcache_rsp_valid;
    logic [DW-1:0] dcache_rsp_data;
    logic [TW-1:0] dcache_rsp_tag;
    logic          dcache_rsp_ready;
    logic          rsp_err;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    vx_l1_mem_sched dut (
        .clk               (clk),
        .reset             (reset),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_tag    (icache_req_tag),
        .icache_req_ready  (icache_req_ready),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_rw     (dcache_req_rw),
        .dcache_req_addr   (dcache_req_addr),
        .dcache_req_data   (dcache_req_data),
        .dcache_req_byteen (dcache_req_byteen),
        .dcache_req_tag    (dcache_req_tag),
        .dcache_req_ready  (dcache_req_ready),
        .mem_req_valid     (mem_req_valid),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_data      (mem_req_data),
        .mem_req_byteen    (mem_req_byteen),
        .mem_req_tag       (mem_req_tag),
        .mem_req_ready     (mem_req_ready),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .mem_rsp_tag       (mem_rsp_tag),
        .mem_rsp_ready     (mem_rsp_ready),
        .icache_rsp_valid  (icache_rsp_valid),
        .icache_rsp_data   (icache_rsp_data),
        .icache_rsp_tag    (icache_rsp_tag),
        .icache_rsp_ready  (icache_rsp_ready),
        .dcache_rsp_valid  (dcache_rsp_valid),
        .dcache_rsp_data   (dcache_rsp_data),
        .dcache_rsp_tag    (dcache_rsp_tag),
        .dcache_rsp_ready  (dcache_rsp_ready),
        .rsp_err           (rsp_err),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_d;
        logic [63:0] exp_tag;

        reset             = 1'b0;
        icache_req_valid  = 1'b0;
        icache_req_addr   = '0;
        icache_req_tag    = '0;
        dcache_req_valid  = 1'b0;
        dcache_req_rw     = 1'b0;
        dcache_req_addr   = '0;
        dcache_req_data   = '0;
        dcache_req_byteen = '0;
        dcache_req_tag    = '0;
        mem_req_ready     = 1'b1;
        mem_rsp_valid     = 1'b0;
        mem_rsp_data      = '0;
        mem_rsp_tag       = '0;
        icache_rsp_ready  = 1'b0;
        dcache_rsp_ready  = 1'b0;

        // reset state
        repeat (2) tick();
        icache_req_valid = 1'b1;
        #1;
        chk("rst_mreq_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_busy",       64'(busy),          64'd0);
        chk("rst_err",        64'(rsp_err),       64'd0);
        chk("rst_iready",     64'(icache_req_ready), 64'd0);
        icache_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        icache_req_valid = 1'b1;
        #1;
        chk("idle_iready", 64'(icache_req_ready), 64'd1);
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b1;
        #1;
        chk("idle_dready", 64'(dcache_req_ready), 64'd1);
        dcache_req_valid = 1'b0;
        tick();

        // priority / starvation: expect I,I,I,I,D,I,I,I,I,D
        dcache_req_byteen = 64'h0F;
        dcache_req_data   = {8{64'hDEAD_BEEF_0000_0001}};
        for (int k = 0; k < 10; k++) begin
            icache_req_valid = 1'b1;
            icache_req_addr  = AW'(k);
            icache_req_tag   = TW'(k);
            dcache_req_valid = 1'b1;
            dcache_req_rw    = 1'b0;
            dcache_req_addr  = AW'(12'h100 + k);
            dcache_req_tag   = TW'(8'h80 | k);
            #1;
            exp_d = (k == 4) || (k == 9);
            chk("prio_iready", 64'(icache_req_ready), 64'(!exp_d));
            chk("prio_dready", 64'(dcache_req_ready), 64'(exp_d));
            tick();
            exp_tag = exp_d ? (64'h180 | 64'(k)) : 64'(k);
            chk("lat_valid", 64'(mem_req_valid), 64'd1);
            chk("lat_tag",   64'(mem_req_tag),   exp_tag);
            if (exp_d) begin
                chk("d_rd_byteen", 64'(mem_req_byteen), 64'hFFFF_FFFF_FFFF_FFFF);
                chk("d_rd_addr",   64'(mem_req_addr),   64'h100 + 64'(k));
            end else begin
                chk("i_data_zero", mem_req_data[63:0], 64'd0);
            end
        end

        // back-pressure: load icache 0x55 then stall five cycles
        icache_req_tag  = 8'h55;
        icache_req_addr = 26'h155;
        dcache_req_tag  = 8'hAA;
        #1;
        chk("bp_load_iready", 64'(icache_req_ready), 64'd1);
        tick();
        mem_req_ready  = 1'b0;
        for (int s = 0; s < 5; s++) begin
            icache_req_tag  = TW'(8'h56 + s);
            icache_req_addr = AW'(12'h200 + s);
            #1;
            chk("bp_iready", 64'(icache_req_ready), 64'd0);
            chk("bp_dready", 64'(dcache_req_ready), 64'd0);
            chk("bp_valid",  64'(mem_req_valid),    64'd1);
            chk("bp_tag",    64'(mem_req_tag),      64'h055);
            chk("bp_addr",   64'(mem_req_addr),     64'h155);
            tick();
        end
        // starve held at 1 through the stall, so I,I,I then D
        mem_req_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            icache_req_tag = TW'(8'h60 + j);
            #1;
            chk("drain_iready", 64'(icache_req_ready), 64'(j < 3));
            chk("drain_dready", 64'(dcache_req_ready), 64'(j == 3));
            tick();
        end
        dcache_req_valid = 1'b0;
        // icache_pend = 12, dcache_pend = 3

        // pending limit
        for (int j = 0; j < 4; j++) begin
            icache_req_tag = TW'(8'h70 + j);
            #1;
            chk("fill_iready", 64'(icache_req_ready), 64'd1);
            tick();
        end
        #1;
        chk("full_iready", 64'(icache_req_ready), 64'd0);
        dcache_req_valid = 1'b1;
        dcache_req_rw    = 1'b0;
        dcache_req_tag   = 8'h11;
        #1;
        chk("full_dready", 64'(dcache_req_ready), 64'd1);
        tick();
        chk("full_dtag", 64'(mem_req_tag), 64'h111);
        dcache_req_valid = 1'b0;
        // icache_pend = 16, dcache_pend = 4

        mem_rsp_valid    = 1'b1;
        mem_rsp_tag      = 9'h022;
        mem_rsp_data     = {8{64'h1234_5678_9ABC_DEF0}};
        icache_rsp_ready = 1'b1;
        #1;
        chk("full_rsp_iready", 64'(icache_req_ready), 64'd0);
        chk("irsp_valid",      64'(icache_rsp_valid), 64'd1);
        chk("irsp_tag",        64'(icache_rsp_tag),   64'h22);
        chk("irsp_data",       icache_rsp_data[63:0], 64'h1234_5678_9ABC_DEF0);
        chk("irsp_mready",     64'(mem_rsp_ready),    64'd1);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("after_rsp_iready", 64'(icache_req_ready), 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 9'h023;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("simul_iready", 64'(icache_req_ready), 64'd1);
        tick();
        #1;
        chk("refull_iready", 64'(icache_req_ready), 64'd0);
        icache_req_valid = 1'b0;
        // icache_pend = 16, dcache_pend = 4

        // response routing
        mem_rsp_valid    = 1'b1;
        mem_rsp_tag      = 9'h13A;
        mem_rsp_data     = {8{64'hA5A5_0000_FFFF_3A3A}};
        dcache_rsp_ready = 1'b0;
        icache_rsp_ready = 1'b1;
        #1;
        chk("drsp_valid",  64'(dcache_rsp_valid), 64'd1);
        chk("drsp_tag",    64'(dcache_rsp_tag),   64'h3A);
        chk("drsp_data",   dcache_rsp_data[63:0], 64'hA5A5_0000_FFFF_3A3A);
        chk("drsp_ivalid", 64'(icache_rsp_valid), 64'd0);
        chk("drsp_mready0", 64'(mem_rsp_ready),   64'd0);
        tick();
        dcache_rsp_ready = 1'b1;
        #1;
        chk("drsp_mready1", 64'(mem_rsp_ready), 64'd1);
        tick();
        // dcache_pend = 3

        for (int j = 0; j < 16; j++) begin
            mem_rsp_tag = 9'(j);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            mem_rsp_tag = 9'(9'h100 + j);
            if (j == 2) chk("drain_busy_last", 64'(busy), 64'd1);
            tick();
        end
        mem_rsp_valid = 1'b0;
        #1;
        chk("drained_busy", 64'(busy),    64'd0);
        chk("drained_err",  64'(rsp_err), 64'd0);

        // dcache writes are not tracked
        dcache_req_valid  = 1'b1;
        dcache_req_rw     = 1'b1;
        dcache_req_byteen = 64'h00FF;
        dcache_req_data   = {8{64'h0000_0000_0000_CAFE}};
        for (int j = 0; j < 3; j++) begin
            dcache_req_tag = TW'(8'h40 + j);
            #1;
            chk("wr_dready", 64'(dcache_req_ready), 64'd1);
            tick();
            chk("wr_rw",     64'(mem_req_rw),        64'd1);
            chk("wr_byteen", 64'(mem_req_byteen),    64'h00FF);
            chk("wr_data",   mem_req_data[63:0],     64'hCAFE);
            chk("wr_tag",    64'(mem_req_tag),       64'h140 + 64'(j));
        end
        dcache_req_valid = 1'b0;
        #1;
        chk("wr_busy_hold", 64'(busy), 64'd1);
        tick();
        chk("wr_busy_drop", 64'(busy), 64'd0);

        // stray icache response
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 9'h001;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("err_set",  64'(rsp_err), 64'd1);
        chk("err_busy", 64'(busy),    64'd0);
        tick();
        chk("err_sticky", 64'(rsp_err), 64'd1);

        // reset mid-transfer
        mem_req_ready    = 1'b0;
        icache_req_valid = 1'b1;
        icache_req_tag   = 8'h77;
        tick();
        icache_req_valid = 1'b0;
        chk("mid_loaded", 64'(mem_req_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_busy",  64'(busy),          64'd0);
        chk("mid_rst_err",   64'(rsp_err),       64'd0);
        @(negedge clk);
        reset         = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        icache_req_valid = 1'b1;
        dcache_req_valid = 1'b0;
        #1;
        chk("post_iready", 64'(icache_req_ready), 64'd1);
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b1;
        dcache_req_rw    = 1'b0;
        #1;
        chk("post_dready", 64'(dcache_req_ready), 64'd1);
        dcache_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
